// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared constants, FSM state type and decode helper
// for the alu_sequencer issue/writeback controller.
package alu_seq_pkg;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_AND = 3'd7;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    typedef enum logic [1:0] {
        IDLE,
        OPERAND,
        EXECUTE,
        WRITEBACK
    } seq_state_e;

    // Only ADD/ADDI/AND/ANDI are executed.
    function automatic logic is_legal(input logic [31:0] w);
        logic f3_ok;
        f3_ok = (w[14:12] == ALU_ADD) || (w[14:12] == ALU_AND);
        is_legal = f3_ok &&
            ((w[6:0] == OPC_OP && w[31:25] == 7'b0) ||
             (w[6:0] == OPC_OP_IMM));
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: instruction handshake plus the ALU operand/result bus.
// master = fetch/ALU side, slave = alu_sequencer.
interface alu_seq_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [2:0]  alu_opcode;
    logic [31:0] alu_left;
    logic [31:0] alu_right;
    logic [31:0] alu_result;
    logic        illegal;

    modport master (
        output instr_valid, instr, alu_result,
        input  instr_ready, alu_opcode, alu_left, alu_right, illegal
    );

    modport slave (
        input  instr_valid, instr, alu_result,
        output instr_ready, alu_opcode, alu_left, alu_right, illegal
    );
endinterface

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: 32x32 register file, x0 reads zero.
// Ports: clk, rst_n, one write port, two read ports, one debug read.
module alu_seq_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    output logic [31:0] rdata_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_b,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);
    logic [31:0] rf [32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (we && waddr != 5'd0) begin
            rf[waddr] <= wdata;
        end
    end

    assign rdata_a  = (raddr_a == 5'd0) ? '0 : rf[raddr_a];
    assign rdata_b  = (raddr_b == 5'd0) ? '0 : rf[raddr_b];
    assign dbg_data = (dbg_addr == 5'd0) ? '0 : rf[dbg_addr];
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: 4-cycle issue/writeback controller for an external ALU.
// Ports: clk, rst_n, bus (alu_seq_if.slave), dbg_addr, dbg_data;
// retired_count only with ALU_SEQ_RETIRE_CNT_EN defined.
module alu_sequencer
    import alu_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    alu_seq_if.slave    bus,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
`ifdef ALU_SEQ_RETIRE_CNT_EN
    ,
    output logic [31:0] retired_count
`endif
);
    seq_state_e  state_q, state_d;
    logic [31:0] instr_q;
    logic [31:0] res_q;
    logic [2:0]  op_q;
    logic [31:0] left_q, right_q;
    logic        illegal_q;

    logic [31:0] rs1_data, rs2_data, imm_ext;
    logic        legal, is_r;

    assign legal   = is_legal(instr_q);
    assign is_r    = instr_q[6:0] == OPC_OP;
    assign imm_ext = {{20{instr_q[31]}}, instr_q[31:20]};

    alu_seq_regfile u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (state_q == WRITEBACK),
        .waddr    (instr_q[11:7]),
        .wdata    (res_q),
        .raddr_a  (instr_q[19:15]),
        .rdata_a  (rs1_data),
        .raddr_b  (instr_q[24:20]),
        .rdata_b  (rs2_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (bus.instr_valid) state_d = OPERAND;
            OPERAND:   state_d = legal ? EXECUTE : IDLE;
            EXECUTE:   state_d = WRITEBACK;
            WRITEBACK: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            res_q     <= '0;
            op_q      <= ALU_ADD;
            left_q    <= '0;
            right_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= (state_q == OPERAND) && !legal;
            if (state_q == IDLE && bus.instr_valid)
                instr_q <= bus.instr;
            // ALU inputs only move on a legal operand edge
            if (state_q == OPERAND && legal) begin
                op_q    <= instr_q[14:12];
                left_q  <= rs1_data;
                right_q <= is_r ? rs2_data : imm_ext;
            end
            if (state_q == EXECUTE)
                res_q <= bus.alu_result;
        end
    end

    assign bus.instr_ready = state_q == IDLE;
    assign bus.alu_opcode  = op_q;
    assign bus.alu_left    = left_q;
    assign bus.alu_right   = right_q;
    assign bus.illegal     = illegal_q;

`ifdef ALU_SEQ_RETIRE_CNT_EN
    logic [31:0] ret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ret_q <= '0;
        else if (state_q == WRITEBACK)
            ret_q <= ret_q + 32'd1;
    end

    assign retired_count = ret_q;
`endif
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed + random self-checking bench with a
// behavioural register-file/ALU model.
module tb_alu_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;
`ifdef ALU_SEQ_RETIRE_CNT_EN
    logic [31:0] retired_count;
`endif

    alu_seq_if bus();

    alu_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
`ifdef ALU_SEQ_RETIRE_CNT_EN
        ,
        .retired_count (retired_count)
`endif
    );

    // The combinational ALU the sequencer drives.
    assign bus.alu_result = (bus.alu_opcode == 3'd7)
        ? (bus.alu_left & bus.alu_right)
        : (bus.alu_left + bus.alu_right);

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int unsigned mregs [32];
    int unsigned m_op, m_left, m_right, m_ret;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h",
                   tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(
        input int f7, input int rs2, input int rs1,
        input int f3, input int rd);
        logic [6:0] a; logic [4:0] b, c, e; logic [2:0] d;
        a = 7'(f7); b = 5'(rs2); c = 5'(rs1);
        d = 3'(f3); e = 5'(rd);
        return {a, b, c, d, e, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(
        input int imm, input int rs1, input int f3,
        input int rd);
        logic [11:0] a; logic [4:0] c, e; logic [2:0] d;
        a = 12'(imm); c = 5'(rs1); d = 3'(f3); e = 5'(rd);
        return {a, c, d, e, 7'b0010011};
    endfunction

    task automatic chk_ret();
`ifdef ALU_SEQ_RETIRE_CNT_EN
        chk("retired_count", retired_count, m_ret);
`endif
    endtask

    // Issue one word and follow it to completion, checking
    // every externally visible step against the model.
    task automatic issue(input logic [31:0] w);
        int unsigned opc, f3, f7, rd, rs1, rs2;
        int unsigned a, b, res;
        bit ok, rtype;
        opc = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        rd = w[11:7]; rs1 = w[19:15]; rs2 = w[24:20];
        rtype = (opc == 'h33);
        ok = (f3 == 0 || f3 == 7) &&
             ((rtype && f7 == 0) || opc == 'h13);
        a = mregs[rs1];
        if (rtype) b = mregs[rs2];
        else b = int'($signed(w[31:20]));
        res = (f3 == 7) ? (a & b) : (a + b);

        @(negedge clk);
        bus.instr = w;
        bus.instr_valid = 1'b1;
        chk("ready_idle", {31'b0, bus.instr_ready}, 1);
        @(negedge clk);
        // a different word held valid while busy must be ignored
        bus.instr = $urandom;
        chk("ready_busy", {31'b0, bus.instr_ready}, 0);
        chk("illegal_e0", {31'b0, bus.illegal}, 0);
        @(negedge clk);
        if (ok) begin
            m_op = f3; m_left = a; m_right = b;
        end
        chk("alu_opcode", {29'b0, bus.alu_opcode}, m_op);
        chk("alu_left", bus.alu_left, m_left);
        chk("alu_right", bus.alu_right, m_right);
        if (!ok) begin
            bus.instr_valid = 1'b0;
            chk("illegal_pulse", {31'b0, bus.illegal}, 1);
            chk("ready_after_ill", {31'b0, bus.instr_ready}, 1);
            @(negedge clk);
            chk("illegal_drop", {31'b0, bus.illegal}, 0);
            dbg_addr = 5'(rd);
            #1;
            chk("rd_unchanged", dbg_data, mregs[rd]);
            chk_ret();
            return;
        end
        chk("illegal_legal", {31'b0, bus.illegal}, 0);
        chk("ready_exec", {31'b0, bus.instr_ready}, 0);
        @(negedge clk);
        dbg_addr = 5'(rd);
        #1;
        chk("dbg_old", dbg_data, mregs[rd]);
        chk("ready_wb", {31'b0, bus.instr_ready}, 0);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        if (rd != 0) mregs[rd] = res;
        m_ret = m_ret + 1;
        chk("dbg_new", dbg_data, mregs[rd]);
        chk("ready_done", {31'b0, bus.instr_ready}, 1);
        chk_ret();
    endtask

    // Build an arbitrary constant with ADDI/ADD doubling.
    task automatic load_const(input int rd, input logic [31:0] v);
        issue(enc_i(0, 0, 0, rd));
        for (int i = 31; i >= 0; i--) begin
            issue(enc_r(0, rd, rd, 0, rd));
            if (v[i]) issue(enc_i(1, rd, 0, rd));
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'b0, bus.instr_ready}, 1);
        chk({tag, "_op"}, {29'b0, bus.alu_opcode}, 0);
        chk({tag, "_left"}, bus.alu_left, 0);
        chk({tag, "_right"}, bus.alu_right, 0);
        chk({tag, "_illegal"}, {31'b0, bus.illegal}, 0);
    endtask

    initial begin
        logic [31:0] w;
        int kind;
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        for (int i = 0; i < 32; i++) mregs[i] = 0;
        m_op = 0; m_left = 0; m_right = 0; m_ret = 0;

        #1;
        chk_reset_outputs("in_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_reset_outputs("after_reset");
        chk_ret();

        issue(32'h00500093);
        issue(enc_i(-1, 0, 0, 1));
        issue(enc_i(1, 0, 0, 2));
        issue(32'h002081B3);
        chk("add_wrap_x3", mregs[3], 0);
        load_const(1, 32'h12345678);
        issue(32'hFF00F213);
        chk("andi_x4", mregs[4], 32'h12345670);
        issue(32'h402082B3);
        issue(enc_i(7, 0, 0, 0));
        issue(enc_r(0, 2, 1, 7, 5));

        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 6);
            case (kind)
                0: w = enc_r(0, $urandom_range(0, 31),
                     $urandom_range(0, 31), 0,
                     $urandom_range(0, 31));
                1: w = enc_r(0, $urandom_range(0, 31),
                     $urandom_range(0, 31), 7,
                     $urandom_range(0, 31));
                2: w = enc_i($urandom_range(0, 4095),
                     $urandom_range(0, 31), 0,
                     $urandom_range(0, 31));
                3: w = enc_i($urandom_range(0, 4095),
                     $urandom_range(0, 31), 7,
                     $urandom_range(0, 31));
                4: w = enc_r($urandom_range(1, 127),
                     $urandom_range(0, 31),
                     $urandom_range(0, 31),
                     ($urandom_range(0, 1) != 0) ? 7 : 0,
                     $urandom_range(0, 31));
                5: w = enc_i($urandom_range(0, 4095),
                     $urandom_range(0, 31),
                     $urandom_range(1, 6),
                     $urandom_range(0, 31));
                default: begin
                    w = $urandom;
                    w[6:0] = 7'b0110111;
                end
            endcase
            issue(w);
        end

        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            dbg_addr = 5'(i);
            #1;
            chk("rf_dump", dbg_data, mregs[i]);
        end

        // Reset during EXECUTE of ADDI x6,x0,9
        @(negedge clk);
        bus.instr = enc_i(9, 0, 0, 6);
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        for (int i = 0; i < 32; i++) mregs[i] = 0;
        m_op = 0; m_left = 0; m_right = 0; m_ret = 0;
        chk_ret();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        dbg_addr = 5'd6;
        #1;
        chk("x6_aborted", dbg_data, 0);
        chk_reset_outputs("post_abort");
        issue(enc_i(-3, 0, 0, 6));
        issue(enc_r(0, 6, 6, 0, 7));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle issue/writeback controller that drives the combinational `alu` block from the other side of its `opcode`/`left`/`right`/`result` interface. It accepts RV32I-encoded ADD, ADDI, AND and ANDI instruction words over a valid/ready handshake. It reads operands from an internal 32×32 register file, presents them to the ALU, and writes the ALU result back to the destination register. It sits between instruction fetch and the `alu` instance in the datapath.

## Interface
Parameters: none.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `instr_valid` input 1: `instr` holds a word to execute.
- `instr_ready` output 1: sequencer can accept a word (high only in IDLE).
- `instr` input 32: RV32I instruction word.
- `alu_opcode` output 3: to ALU `opcode` (0 = ADD, 7 = AND, i.e. funct3).
- `alu_left` output 32: to ALU `left`.
- `alu_right` output 32: to ALU `right`.
- `alu_result` input 32: from ALU `result`.
- `illegal` output 1: one-cycle pulse, instruction rejected.
- `dbg_addr` input 5: debug register read address.
- `dbg_data` output 32: combinational read of `rf[dbg_addr]`.

## Operation
- FSM states:
  - IDLE → OPERAND on `instr_valid && instr_ready`; `instr` is latched.
  - OPERAND → EXECUTE if the instruction is legal, else → IDLE with `illegal` pulsed.
  - EXECUTE → WRITEBACK.
  - WRITEBACK → IDLE.
- Legal encodings:
  - opcode 0110011 with funct7 = 0000000 and funct3 ∈ {000, 111}.
  - opcode 0010011 with funct3 ∈ {000, 111}.
  - Everything else is illegal: no register write, no ALU output change.
- OPERAND edge:
  - `alu_opcode` ← funct3.
  - `alu_left` ← `rf[rs1]`.
  - `alu_right` ← `rf[rs2]` for R-type, or the 12-bit immediate sign-extended to 32 bits for I-type.
- EXECUTE edge: `res_q` ← `alu_result`, with the ALU settled for a full cycle.
- WRITEBACK edge: `rf[rd]` ← `res_q` unless rd = 0.
- `rf[0]` always reads 0, and writes to it are discarded.
- Arithmetic is modulo 2^32: ADD wraps and there is no carry or overflow flag.
- `alu_opcode`, `alu_left` and `alu_right` hold their values until the next legal OPERAND edge.
- Instructions are fully serialized, so no hazards are possible.

## Timing
- Reset values:
  - State = IDLE, so `instr_ready` = 1 during and after reset.
  - `alu_opcode` = 0, `alu_left` = 0, `alu_right` = 0.
  - `illegal` = 0, `res_q` = 0.
  - All `rf` entries = 0.
- Edge sequence, with E0 being the accepting edge:
  - E1: operands are latched.
  - E2: result is captured.
  - E3: register file is written.
  - `dbg_data` shows the new value from E3 onward.
- Throughput is one instruction per 4 cycles; `instr_ready` is low from E0 to E3.
- Illegal path: `illegal` is high for exactly the cycle after E1, and `instr_ready` returns high after E1 (a 2-cycle occupancy).
- `instr_valid` while `instr_ready` is low is ignored; the word is not latched.
- Asserting `rst_n` mid-instruction aborts it immediately with no writeback, and all state returns to its reset values.
- A debug read of rd in the WRITEBACK cycle returns the old value.

## Configuration
- `ALU_SEQ_RETIRE_CNT_EN` defined:
  - Adds output `retired_count` [31:0], reset to 0.
  - It increments on every WRITEBACK edge, including rd = 0, and never on illegal instructions.
  - It wraps from 0xFFFFFFFF to 0.
- Undefined: the port and its counter logic are absent.

## Structure
- Package `alu_seq_pkg` holds:
  - ALU opcode constants `ALU_ADD` = 3'd0 and `ALU_AND` = 3'd7.
  - RV32I opcode constants `OPC_OP` = 7'b0110011 and `OPC_OP_IMM` = 7'b0010011.
  - The FSM state enum: IDLE, OPERAND, EXECUTE, WRITEBACK.
- Sub-module `alu_seq_regfile`:
  - 32×32 flops with asynchronous active-low reset.
  - Two combinational read ports plus a debug read port, one write port.
  - x0 hardwired to zero.

## Test plan
- After reset, ADDI x1,x0,5 (0x00500093) → `dbg_data`[x1] = 5 at E3; `alu_opcode` = 0, `alu_left` = 0, `alu_right` = 5 after E1.
- With x1 = 0xFFFFFFFF and x2 = 1, ADD x3,x1,x2 (0x002081B3) → x3 = 0x00000000 (wrap).
- ANDI x4,x1,-16 (0xFF00F213) with x1 = 0x12345678 → `alu_right` = 0xFFFFFFF0, x4 = 0x12345670.
- SUB x5,x1,x2 (0x402082B3) → one-cycle `illegal` pulse, x5 unchanged, `instr_ready` high 2 cycles after accept.
- ADDI x0,x0,7 → x0 still reads 0; with `ALU_SEQ_RETIRE_CNT_EN` defined, `retired_count` increments by 1.
- Assert `rst_n` low during EXECUTE of ADDI x6,x0,9 → x6 = 0, all outputs at reset values, `instr_ready` = 1.
